// File: rtl/nalu_stream_ctrl.sv
// NAL-unit stream sequencer: paces read_nalu, classifies detected units,
// dispatches VPS/SPS/PPS/slice headers to the parsers and detects end of stream.
module nalu_stream_ctrl #(
  parameter int BUF_AW     = 6,
  parameter int MIN_FREE   = 4,
  parameter int TAIL_BYTES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       stream_len,
  input  logic [31:0]       stream_mem_addr_in,
  input  logic [5:0]        nal_unit_type_in,
  input  logic              next_nalu_detected_in,
  output logic              next_nalu_detected_clr,
  output logic              nalu_en,
  output logic              rd_req,
  input  logic [BUF_AW:0]   rbsp_buf_free_in,
  output logic              parse_start,
  output logic [1:0]        parse_type,
  input  logic              parse_done_in,
  output logic [15:0]       nalu_count,
  output logic              busy,
  output logic              stream_end,
  output logic              timeout_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [BUF_AW:0] FREE_MIN = (BUF_AW + 1)'(MIN_FREE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DISP,
    S_PARSE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     len_q, len_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [1:0]      ptype_q, ptype_d;

  logic            fetch_end;
  logic [32:0]     fetch_lim;
  logic            sup;
  logic [1:0]      mtype;
  logic            active;

  // 33-bit compare so len near 2^32 cannot wrap the limit
  assign fetch_lim = {1'b0, len_q} + 33'(TAIL_BYTES);
  assign fetch_end = {1'b0, stream_mem_addr_in} >= fetch_lim;

  always_comb begin
    sup   = 1'b1;
    mtype = 2'd0;
    unique case (nal_unit_type_in)
      6'd32:        mtype = 2'd0;
      6'd33:        mtype = 2'd1;
      6'd34:        mtype = 2'd2;
      6'd1, 6'd19:  mtype = 2'd3;
      default:      sup   = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wd_d    = wd_q;
    ptype_d = ptype_q;
    next_nalu_detected_clr = 1'b0;
    parse_start = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = stream_len;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (fetch_end)                  state_d = S_DONE;
        else if (next_nalu_detected_in) state_d = S_DISP;
      end
      S_DISP: begin
        next_nalu_detected_clr = 1'b1;
        wd_d = '0;
        if (sup) begin
          parse_start = 1'b1;
          ptype_d     = mtype;
          state_d     = S_PARSE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PARSE: begin
        if (parse_done_in) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          wd_d    = '0;
          state_d = fetch_end ? S_DONE : S_RUN;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      ptype_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      ptype_q <= ptype_d;
    end
  end

  assign active      = (state_q == S_RUN) || (state_q == S_DISP) ||
                       (state_q == S_PARSE);
  assign nalu_en     = active;
  assign busy        = active;
  assign stream_end  = (state_q == S_DONE);
  assign rd_req      = active && (rbsp_buf_free_in >= FREE_MIN) && !fetch_end;
  // Type is valid alongside the parse_start pulse, then held
  assign parse_type  = parse_start ? mtype : ptype_q;
  assign nalu_count  = cnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_nalu_stream_ctrl.sv
// Scoreboard bench for nalu_stream_ctrl: driver plays read_nalu and parsers,
// monitor checks dispatch pulses, count updates and read-request pacing.
module tb_nalu_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] stream_len = '0;
  logic [31:0] addr = '0;
  logic [5:0]  ntype = '0;
  logic        det = 1'b0;
  logic        clr;
  logic        nalu_en;
  logic        rd_req;
  logic [6:0]  free = 7'd64;
  logic        parse_start;
  logic [1:0]  parse_type;
  logic        done = 1'b0;
  logic [15:0] nalu_count;
  logic        busy;
  logic        stream_end;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  typedef struct { logic sup; logic [1:0] pt; } disp_t;
  disp_t       dq[$];
  logic [15:0] cq[$];
  int          tmap[int];
  logic [31:0] len_ref = '0;
  int          mcnt = 0;
  bit          mon_on = 0;
  bit          rnd_free = 0;
  logic [15:0] prev_cnt = '0;

  nalu_stream_ctrl #(
    .BUF_AW(6), .MIN_FREE(4), .TAIL_BYTES(4), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stream_len(stream_len),
    .stream_mem_addr_in(addr),
    .nal_unit_type_in(ntype),
    .next_nalu_detected_in(det),
    .next_nalu_detected_clr(clr),
    .nalu_en(nalu_en),
    .rd_req(rd_req),
    .rbsp_buf_free_in(free),
    .parse_start(parse_start),
    .parse_type(parse_type),
    .parse_done_in(done),
    .nalu_count(nalu_count),
    .busy(busy),
    .stream_end(stream_end),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (rnd_free) free = 7'($urandom_range(0, 8));
  endtask

  // Monitor: pops expectations when the DUT presents a dispatch or count change
  always @(negedge clk) begin
    if (rst) begin
      prev_cnt = '0;
    end else if (mon_on) begin
      if (clr) begin
        if (dq.size() == 0) begin
          chk("clr_unexpected", 1, 0);
        end else begin
          disp_t e;
          e = dq.pop_front();
          chk("pstart", parse_start, e.sup);
          if (e.sup) chk("ptype", parse_type, e.pt);
        end
      end else begin
        chk("pstart_stray", parse_start, 0);
      end
      if (nalu_count !== prev_cnt) begin
        if (cq.size() == 0) chk("cnt_unexpected", nalu_count, prev_cnt);
        else chk("nalu_count", nalu_count, cq.pop_front());
        prev_cnt = nalu_count;
      end
      chk("en_vs_busy", nalu_en, busy);
      chk("rd_req", rd_req, nalu_en && (free >= 7'd4) &&
          ({1'b0, addr} < {1'b0, len_ref} + 33'd4));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, nalu_en, 0);
    chk({tag, "_rd"}, rd_req, 0);
    chk({tag, "_clr"}, clr, 0);
    chk({tag, "_ps"}, parse_start, 0);
    chk({tag, "_pt"}, parse_type, 0);
    chk({tag, "_cnt"}, nalu_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_end"}, stream_end, 0);
    chk({tag, "_err"}, timeout_err, 0);
  endtask

  task automatic do_start(input logic [31:0] len);
    addr = '0;
    stream_len = len;
    start = 1'b1;
    len_ref = len;
    if (mcnt != 0) cq.push_back(16'd0);
    mcnt = 0;
    tick;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_after_start", timeout_err, 0);
  endtask

  task automatic wait_clr(input int exp_lat);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (!clr && n < 8);
    chk("clr_seen", clr, 1);
    if (exp_lat > 0) chk("clr_latency", n, exp_lat);
    det = 1'b0;
  endtask

  task automatic push_disp(input int t);
    disp_t e;
    e.sup = tmap.exists(t);
    e.pt = e.sup ? 2'(tmap[t]) : 2'd0;
    dq.push_back(e);
  endtask

  task automatic nal(input int t, input int lat);
    push_disp(t);
    ntype = 6'(t);
    det = 1'b1;
    wait_clr(lat);
    if (!tmap.exists(t)) tick;
  endtask

  task automatic pulse_done;
    done = 1'b1;
    if (mcnt < 65535) mcnt++;
    cq.push_back(16'(mcnt));
    tick;
    done = 1'b0;
  endtask

  task automatic finish_parse(input int dly);
    tick;
    repeat (dly) tick;
    pulse_done;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int tl[10];
    tmap[32] = 0; tmap[33] = 1; tmap[34] = 2; tmap[1] = 3; tmap[19] = 3;
    tl = '{32, 33, 34, 1, 19, 39, 35, 0, 40, 20};

    rst = 1'b1;
    tick; tick;
    chk_zero("reset");
    rst = 1'b0;
    mon_on = 1;

    // Basic dispatch and full header sequence
    do_start(100);
    nal(32, 1); finish_parse(2);
    chk("cnt_1", nalu_count, 1);
    nal(33, 1); finish_parse(0);
    nal(34, 1); finish_parse(3);
    nal(19, 1); finish_parse(1);
    nal(1, 1);  finish_parse(0);
    chk("cnt_5", nalu_count, 5);
    addr = 103; tick;
    chk("addr103_busy", busy, 1);
    chk("addr103_rd", rd_req, 1);
    addr = 104; tick;
    chk("eos_end", stream_end, 1);
    chk("eos_busy", busy, 0);
    chk("eos_rd", rd_req, 0);

    // Unsupported type: clr only, count unchanged
    do_start(100);
    nal(32, 1); finish_parse(1);
    nal(39, 1);
    chk("sei_cnt", nalu_count, 1);
    chk("sei_run", busy, 1);

    // Free-space pacing during PARSE, then a unit pending across PARSE
    nal(33, 1);
    tick;
    for (int i = 0; i < 6; i++) begin
      free = (i % 2 == 0) ? 7'd3 : 7'd4;
      #1;
      chk("pace_rd", rd_req, (i % 2 == 0) ? 0 : 1);
      chk("pace_en", nalu_en, 1);
      tick;
    end
    free = 7'd64;
    push_disp(34);
    ntype = 6'd34;
    det = 1'b1;
    tick; tick;
    pulse_done;
    wait_clr(1);
    finish_parse(0);
    chk("pend_cnt", nalu_count, 3);

    // Watchdog expiry after 16 PARSE cycles
    nal(33, 1);
    repeat (16) tick;
    chk("wd_busy15", busy, 1);
    chk("wd_err15", timeout_err, 0);
    tick;
    chk("wd_err", timeout_err, 1);
    chk("wd_done", stream_end, 1);
    chk("wd_cnt", nalu_count, 3);

    // Restart clears error; done on the last watchdog cycle wins
    do_start(100);
    nal(32, 1);
    repeat (16) tick;
    pulse_done;
    chk("race_err", timeout_err, 0);
    chk("race_busy", busy, 1);
    chk("race_cnt", nalu_count, 1);

    // Reset while parsing, then start while busy is ignored
    nal(34, 1);
    tick;
    rst = 1'b1;
    tick;
    chk_zero("midrst");
    rst = 1'b0;
    mcnt = 0;
    dq.delete();
    cq.delete();
    do_start(100);
    stream_len = 20;
    start = 1'b1;
    tick;
    start = 1'b0;
    addr = 30; tick;
    chk("ign_start_busy", busy, 1);
    addr = 104; tick;
    chk("ign_start_end", stream_end, 1);

    // Randomised unit stream
    do_start(1000);
    rnd_free = 1;
    for (int k = 0; k < 40; k++) begin
      int t;
      t = tl[$urandom_range(0, 9)];
      addr = addr + 32'($urandom_range(1, 10));
      nal(t, 1);
      if (tmap.exists(t)) finish_parse($urandom_range(0, 5));
    end
    chk("rnd_cnt", nalu_count, 16'(mcnt));
    addr = 1004; tick;
    chk("rnd_end", stream_end, 1);
    rnd_free = 0;
    tick;

    chk("dq_drained", dq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
